uart_rx: RTL and testbench

Serial receive front end for the UART receiver path. It synchronises the asynchronous `rx` line and detects and validates start bits. It samples 8 data bits LSB-first at mid-bit, checks the stop bit and, optionally, a parity bit. Each good byte is presented to the downstream byte FIFO as a single-cycle write strobe with data. The block sits directly upstream of the FIFO: `dataOut`/`WR` connect to the FIFO's `dataIn`/`WR`, and the FIFO's `FULL` returns as `full`.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx_sync2.sv | 30 +++
 rtl/uart_rx.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Declarations shared by the UART receive path and the future transmitter:
// the frame width, the default bit period, and the receiver state type.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

    // Data bits per frame
    localparam int UART_DATA_BITS = 8;

    // Default bit period in clk cycles: 100 MHz / 115200 baud
    localparam int UART_CLKS_PER_BIT = 868;

    // PARITY is only entered when UART_RX_PARITY_EN is defined
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Byte write bus between the UART receiver and the downstream byte FIFO.
//   dataOut : received byte, valid while WR is high
//   WR      : single-cycle write strobe into the FIFO
//   full    : FIFO full, returned to the receiver
// Modports:
//   master : the receiver (drives dataOut/WR, observes full)
//   slave  : the FIFO     (observes dataOut/WR, drives full)
// ---------------------------------------------------------------------------
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] dataOut;
    logic                      WR;
    logic                      full;

    modport master (output dataOut, output WR, input full);
    modport slave  (input dataOut, input WR, output full);

endinterface

// File: rtl/uart_rx_sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for a single asynchronous bit. Both flops reset to 1
// so an idle-high serial line shows no spurious falling edge out of reset.
// Ports:
//   clk   : destination clock
//   reset : synchronous, active-high
//   d     : asynchronous input
//   q     : synchronised output (2 cycles of latency)
// ---------------------------------------------------------------------------
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Serial receive front end: synchronises rx, validates the start bit,
// samples 8 data bits LSB-first at mid-bit, checks the stop bit (and the
// parity bit when compiled in) and writes each good byte to the FIFO with a
// one-cycle strobe.
// Build option: define UART_RX_PARITY_EN to add a parity bit between data
// and stop (PARITY_ODD selects the sense); otherwise frames are 8N1 and
// parity_err is constant 0.
// Parameters:
//   CLKS_PER_BIT : clk cycles per bit (>= 4)
//   PARITY_ODD   : 0 = even parity, 1 = odd parity
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high
//   rx         : asynchronous serial line, idle high
//   bus        : FIFO write bus (dataOut, WR out; full in)
//   busy       : high whenever the receiver is not idle
//   frame_err  : one-cycle pulse, stop bit sampled low
//   parity_err : one-cycle pulse, parity mismatch
//   overrun    : one-cycle pulse, good byte dropped because the FIFO was full
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int PARITY_ODD   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    uart_rx_if.master        bus,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    // Start bit is confirmed half a bit in; later samples are a full bit
    // apart, which lands each one near the middle of its bit.
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                      rxs;
    logic                      rxs_d;
    logic                      bit_tick;
    uart_rx_state_t            state;
    logic [CW-1:0]             cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;

`ifdef UART_RX_PARITY_EN
    logic                      par_bad;
    logic                      parity_err_q;
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    sync2 u_sync2 (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rxs)
    );

    assign bit_tick = (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            rxs_d       <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            bus.dataOut <= '0;
            bus.WR      <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rxs_d     <= rxs;
            bus.WR    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif

            case (state)
                IDLE: begin
                    if (rxs_d && !rxs) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF_CNT) begin
                        cnt <= '0;
                        if (rxs) begin
                            // line went back high: glitch, not a start bit
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        shift <= {rxs, shift[UART_DATA_BITS-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        par_bad <= ^shift ^ rxs ^ PARITY_ODD[0];
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (bit_tick) begin
                        cnt <= '0;
                        if (!rxs) begin
                            // busy stays high until the line recovers
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad) begin
                            parity_err_q <= 1'b1;
                            state        <= IDLE;
                            busy         <= 1'b0;
`endif
                        end else if (bus.full) begin
                            overrun <= 1'b1;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            bus.dataOut <= shift;
                            bus.WR      <= 1'b1;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_HIGH: begin
                    // a held-low (break) line must not produce repeated frames
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx at CLKS_PER_BIT = 8. Frames are driven
// bit by bit; a frame-level model predicts the outcome of each frame (write,
// framing error, parity error or overrun) and the observed pulses are
// compared against that prediction. Honours UART_RX_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB  = 8;
    localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int EV_WR = 1;
    localparam int EV_FE = 2;
    localparam int EV_PE = 3;
    localparam int EV_OV = 4;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    logic rx;
    logic busy;
    logic frame_err;
    logic parity_err;
    logic overrun;

    uart_rx_if bus ();

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .PARITY_ODD   (PODD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .bus        (bus),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    ev_t        act_q[$];
    ev_t        exp_q[$];
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Collect output pulses away from the active edge
    always @(negedge clk) begin
        int n;
        if (!reset) begin
            n = int'(bus.WR) + int'(frame_err) + int'(parity_err) + int'(overrun);
            if (n != 0) begin
                check("one_pulse", n, 1);
                if (bus.WR)     act_q.push_back('{EV_WR, bus.dataOut, cyc});
                if (frame_err)  act_q.push_back('{EV_FE, 8'h00, cyc});
                if (parity_err) act_q.push_back('{EV_PE, 8'h00, cyc});
                if (overrun)    act_q.push_back('{EV_OV, 8'h00, cyc});
            end
        end
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return logic'(($countones(d) + PODD) % 2);
    endfunction

    // Drive one frame and record what the frame rules say must come out
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic pbit, input logic fullv);
        bus.full = fullv;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
        if (PAR_EN) hold(pbit, CPB);
        hold(stop_bit, CPB);

        if (!stop_bit)
            exp_q.push_back('{EV_FE, 8'h00, 0});
        else if (PAR_EN && ((($countones(d) + int'(pbit)) % 2) != PODD))
            exp_q.push_back('{EV_PE, 8'h00, 0});
        else if (fullv)
            exp_q.push_back('{EV_OV, 8'h00, 0});
        else begin
            exp_q.push_back('{EV_WR, d, 0});
            last_good = d;
        end
    endtask

    task automatic compare_events(input string tag);
        int n;
        check({tag, "_count"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_kind"}, act_q[i].kind, exp_q[i].kind);
            check({tag, "_data"}, act_q[i].data, exp_q[i].data);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int         t0;
        int         lat;
        logic [7:0] d;
        logic       fe;
        logic       fullv;
        logic       pbit;

        rx       = 1'b1;
        reset    = 1'b1;
        bus.full = 1'b0;
        @(posedge clk);
        #1;
        hold(1'b1, 3);

        check("rst_wr",      bus.WR, 0);
        check("rst_dataout", bus.dataOut, 8'h00);
        check("rst_busy",    busy, 0);
        check("rst_fe",      frame_err, 0);
        check("rst_pe",      parity_err, 0);
        check("rst_ov",      overrun, 0);

        reset = 1'b0;
        hold(1'b1, 2 * CPB);

        // Good byte with latency from start edge to WR
        t0 = cyc;
        send_frame(8'hA5, 1'b1, good_par(8'hA5), 1'b0);
        hold(1'b1, 2 * CPB);
        lat = (act_q.size() > 0) ? (act_q[0].cyc - t0) : -1;
        check("wr_latency_in_77_79", (lat >= 77 && lat <= 79), 1);
        check("good_dataout", bus.dataOut, 8'hA5);
        check("good_busy", busy, 0);
        compare_events("good");

        // Glitch shorter than half a bit
        hold(1'b0, 2);
        hold(1'b1, 12);
        check("glitch_busy", busy, 0);
        compare_events("glitch");

        // Framing error, break, then recovery
        send_frame(8'h3C, 1'b0, good_par(8'h3C), 1'b0);
        hold(1'b0, 40);
        check("break_busy", busy, 1);
        hold(1'b1, 2 * CPB);
        check("break_recover_busy", busy, 0);
        send_frame(8'h5A, 1'b1, good_par(8'h5A), 1'b0);
        hold(1'b1, 2 * CPB);
        compare_events("frame_err");

        // Overrun keeps previous dataOut
        send_frame(8'h81, 1'b1, good_par(8'h81), 1'b1);
        hold(1'b1, 2 * CPB);
        check("overrun_dataout_kept", bus.dataOut, last_good);
        send_frame(8'h7E, 1'b1, good_par(8'h7E), 1'b0);
        hold(1'b1, 2 * CPB);
        check("after_overrun_dataout", bus.dataOut, 8'h7E);
        compare_events("overrun");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 2 * CPB);
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        hold(1'b1, 2 * CPB);
        compare_events("parity");
`endif

        // Reset in the middle of bit 4, then back-to-back frames
        d = 8'h55;
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(d[i], CPB);
        hold(d[4], CPB / 2);
        reset = 1'b1;
        hold(1'b1, 2);
        check("midframe_reset_busy", busy, 0);
        reset = 1'b0;
        hold(1'b1, CPB);
        send_frame(8'h00, 1'b1, good_par(8'h00), 1'b0);
        send_frame(8'hFF, 1'b1, good_par(8'hFF), 1'b0);
        hold(1'b1, 2 * CPB);
        compare_events("b2b");

        // Randomized frames with random faults, full and idle gaps
        for (int k = 0; k < 40; k++) begin
            d     = 8'($urandom);
            fe    = ($urandom_range(0, 7) == 0);
            fullv = ($urandom_range(0, 3) == 0);
            pbit  = good_par(d) ^ ($urandom_range(0, 3) == 0);
            send_frame(d, !fe, pbit, fullv);
            if (fe) begin
                hold(1'b0, $urandom_range(0, 20));
                hold(1'b1, CPB + $urandom_range(0, CPB));
            end else begin
                hold(1'b1, $urandom_range(0, 2) * CPB);
            end
        end
        hold(1'b1, 3 * CPB);
        check("random_dataout", bus.dataOut, last_good);
        check("random_busy", busy, 0);
        compare_events("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
